// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/mem/writeback plus ALU decoder.
// One instruction in flight, 2-5 cycles each; all strobes decode from state and are blanked while reset is low.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               memwrite,
  output logic               iord,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic [2:0]         alucontrol,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;

  state_t     state_q, state_d;
  logic       memwrite_c, iord_c, irwrite_c, regdst_c, memtoreg_c, regwrite_c, alusrca_c;
  logic [1:0] alusrcb_c, pcsrc_c, aluop;
  logic       pcwrite, branch, illegal;
  logic [2:0] alu_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    memwrite_c = 1'b0;
    iord_c     = 1'b0;
    irwrite_c  = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    pcsrc_c    = 2'b00;
    aluop      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb_c = 2'b01;
        irwrite_c = 1'b1;
        pcwrite   = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        // ALU computes PC + (imm << 2) here so BEQEX can load ALUOut as the target.
        alusrcb_c = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        if (op == OP_LW)      state_d = MEMRD;
        else if (op == OP_SW) state_d = MEMWR;
        else                  state_d = FETCH;
      end
      MEMRD: begin
        iord_c  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
      end
      MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
      end
      RTYPEEX: begin
        alusrca_c = 1'b1;
        aluop     = 2'b10;
        state_d   = RTYPEWB;
      end
      RTYPEWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
      end
      BEQEX: begin
        alusrca_c = 1'b1;
        aluop     = 2'b01;
        pcsrc_c   = 2'b01;
        branch    = 1'b1;
      end
      ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB:  regwrite_c = 1'b1;
      JEX: begin
        pcsrc_c = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    alu_c = 3'b010;
    case (aluop)
      2'b01: alu_c = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alu_c = 3'b110;
          6'b100100: alu_c = 3'b000;
          6'b100101: alu_c = 3'b001;
          6'b101010: alu_c = 3'b111;
          default:   alu_c = 3'b010;
        endcase
      end
      default: alu_c = 3'b010;
    endcase
  end

  // Reset gates the strobes directly so a write cannot fire in the cycle reset lands.
  assign memwrite   = reset & memwrite_c;
  assign iord       = reset & iord_c;
  assign irwrite    = reset & irwrite_c;
  assign regdst     = reset & regdst_c;
  assign memtoreg   = reset & memtoreg_c;
  assign regwrite   = reset & regwrite_c;
  assign alusrca    = reset & alusrca_c;
  assign alusrcb    = reset ? alusrcb_c : 2'b00;
  assign pcsrc      = reset ? pcsrc_c : 2'b00;
  assign pcen       = reset & (pcwrite | (branch & zero));
  assign alucontrol = reset ? alu_c : 3'b000;
  assign illegal_op = reset & illegal;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction step model checked every cycle, plus literal spot checks.
module tb_multicycle_controller;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  typedef struct packed {
    logic       memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal_op;
  } outs_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  multicycle_controller #(.STATE_W(4)) dut (
    .clock(clock), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  logic [5:0] m_op = '0, m_funct = '0;
  logic       m_zero = 1'b0;
  int         m_step = 0;
  logic       m_rst = 1'b0;
  logic       m_check = 1'b0;
  outs_t      snap;
  logic [3:0] snap_state;

  function automatic int instr_len(input logic [5:0] o);
    case (o)
      LW:            return 5;
      SW, RT, ADDI:  return 4;
      BEQ, JMP:      return 3;
      default:       return 2;
    endcase
  endfunction

  function automatic logic [2:0] rfunct(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for cycle 'step' of an instruction (step 0 = fetch).
  function automatic outs_t model(input logic [5:0] o, input logic [5:0] f, input logic z, input int step);
    outs_t e;
    e = '0;
    e.alucontrol = 3'b010;
    if (step == 0) begin
      e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1;
    end else if (step == 1) begin
      e.alusrcb = 2'b11;
      e.illegal_op = (instr_len(o) == 2);
    end else begin
      case (o)
        LW, SW: begin
          if (step == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
          else if (o == LW && step == 3) e.iord = 1'b1;
          else if (o == LW) begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
          else begin e.iord = 1'b1; e.memwrite = 1'b1; end
        end
        RT: begin
          if (step == 2) begin e.alusrca = 1'b1; e.alucontrol = rfunct(f); end
          else begin e.regdst = 1'b1; e.regwrite = 1'b1; end
        end
        BEQ: begin
          e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z;
        end
        ADDI: begin
          if (step == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
          else e.regwrite = 1'b1;
        end
        JMP: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  function automatic outs_t cur_outs();
    return {memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, pcsrc, pcen, alucontrol, illegal_op};
  endfunction

  always @(negedge clock) begin
    outs_t e, a;
    if (m_check) begin
      e = m_rst ? outs_t'(0) : model(m_op, m_funct, m_zero, m_step);
      a = cur_outs();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs op=%b step=%0d rst=%0d got=%b want=%b", m_op, m_step, m_rst, a, e);
      end
      total++;
      if ((state == 4'd0) !== (m_rst || m_step == 0)) begin
        bad++;
        $display("FAIL state_fetch op=%b step=%0d got state=%0d want fetch=%0d",
                 m_op, m_step, state, (m_rst || m_step == 0));
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic set_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
    m_op = o; m_funct = f; m_zero = z;
  endtask

  // Entered and left at posedge+1; snapshots outputs at step 'pick'.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int pick);
    int n;
    n = instr_len(o);
    set_instr(o, f, z);
    for (int s = 0; s < n; s++) begin
      m_step = s;
      #2;
      if (s == pick) begin
        snap = cur_outs();
        snap_state = state;
      end
      @(posedge clock); #1;
    end
  endtask

  // Runs o up to step 'at', drops reset mid-cycle, snapshots, holds two edges, releases.
  task automatic abort_at(input logic [5:0] o, input int at);
    set_instr(o, 6'b100000, 1'b0);
    for (int s = 0; s <= at; s++) begin
      m_step = s;
      if (s < at) begin @(posedge clock); #1; end
    end
    #1;
    reset = 1'b0;
    m_rst = 1'b1;
    #1;
    snap = cur_outs();
    snap_state = state;
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    m_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_instr(RT, 6'b100000, 1'b0);
    #1 reset = 1'b0;
    m_rst = 1'b1;
    m_check = 1'b1;
    #1;
    lit("reset_state", state, 0);
    lit("reset_outs", cur_outs(), 0);
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    m_rst = 1'b0;

    run_instr(LW, 6'b000000, 1'b0, 3);
    lit("lw_memrd_iord", snap.iord, 1);
    lit("lw_back_to_fetch", state, 0);
    run_instr(LW, 6'b000000, 1'b0, 4);
    lit("lw_memwb_wr", {snap.regwrite, snap.memtoreg, snap.regdst}, 3'b110);
    run_instr(SW, 6'b000000, 1'b0, 3);
    lit("sw_memwrite", snap.memwrite, 1);
    run_instr(RT, 6'b100000, 1'b0, 2);
    lit("r_add_alu", snap.alucontrol, 3'b010);
    run_instr(RT, 6'b101010, 1'b0, 2);
    lit("r_slt_alu", snap.alucontrol, 3'b111);
    run_instr(RT, 6'b100010, 1'b0, 3);
    lit("r_wb", {snap.regwrite, snap.regdst}, 2'b11);
    run_instr(RT, 6'b100100, 1'b0, -1);
    run_instr(RT, 6'b100101, 1'b0, -1);
    run_instr(RT, 6'b111111, 1'b0, 2);
    lit("r_bad_funct_alu", snap.alucontrol, 3'b010);
    run_instr(BEQ, 6'b000000, 1'b1, 2);
    lit("beq_taken", {snap.pcen, snap.pcsrc}, 3'b101);
    run_instr(BEQ, 6'b000000, 1'b0, 2);
    lit("beq_not_taken_pcen", snap.pcen, 0);
    run_instr(ADDI, 6'b000000, 1'b0, 3);
    lit("addi_wb", {snap.regwrite, snap.regdst, snap.memtoreg}, 3'b100);
    run_instr(JMP, 6'b000000, 1'b0, 2);
    lit("j_jex", {snap.pcen, snap.pcsrc}, 3'b110);
    run_instr(BAD, 6'b000000, 1'b0, 1);
    lit("illegal_flag", snap.illegal_op, 1);
    lit("illegal_to_fetch", state, 0);

    abort_at(LW, 3);
    lit("rst_memrd_state", snap_state, 0);
    lit("rst_memrd_outs", snap, 0);
    run_instr(ADDI, 6'b000000, 1'b0, 1);
    lit("after_rst_decode_not_fetch", (snap_state != 4'd0), 1);
    abort_at(SW, 3);
    lit("rst_memwr_memwrite", snap.memwrite, 0);
    abort_at(RT, 3);
    lit("rst_rtwb_regwrite", snap.regwrite, 0);
    run_instr(LW, 6'b000000, 1'b0, 0);
    lit("after_rst_fetch", {snap.irwrite, snap.pcen}, 2'b11);

    m_check = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle MIPS datapath: a Moore state machine that sequences fetch, decode, execute, memory and writeback for each instruction, plus an ALU decoder. It sits beside the datapath and drives its register-enable and mux-select strobes from the instruction's `op` and `funct` fields and the ALU `zero` flag. One instruction is in flight at a time. Supported instructions: lw, sw, R-type (add, sub, and, or, slt), beq, addi, j.

## Interface
- `STATE_W`, 4, width of the state register and `state` debug output.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  6  instruction[31:26] from the instruction register.
- `funct`  in  6  instruction[5:0].
- `zero`  in  1  ALU result == 0.
- `memwrite`  out  1  memory write strobe.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `irwrite`  out  1  instruction register load.
- `regdst`  out  1  write register: 0 = rt, 1 = rd.
- `memtoreg`  out  1  write data: 0 = ALUOut, 1 = data register.
- `regwrite`  out  1  register file write.
- `alusrca`  out  1  ALU A: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B: 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2.
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcen`  out  1  PC load = pcwrite | (branch & zero).
- `alucontrol`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal_op`  out  1  one-cycle flag for an unsupported opcode.
- `state`  out  STATE_W  current state (debug).

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1. Next state is DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. This precomputes the branch target.
  - lw or sw goes to MEMADR.
  - op 000000 goes to RTYPEEX.
  - 000100 goes to BEQEX.
  - 001000 goes to ADDIEX.
  - 000010 goes to JEX.
  - Any other opcode asserts `illegal_op` and goes to FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw (100011) goes to MEMRD; sw (101011) goes to MEMWR.
- MEMRD: iord=1, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, then FETCH.
- MEMWR: iord=1, memwrite=1, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10, then RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1, then FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00, then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, then FETCH.
- JEX: pcsrc=10, pcwrite=1, then FETCH.
- Any signal not listed for a state is 0 in that state. An unreachable state encoding returns to FETCH with all strobes at 0.
- ALU decoder:
  - aluop 00 gives add (010).
  - aluop 01 gives sub (110).
  - aluop 10 decodes `funct`: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111. Any other funct gives 010.
- Outputs are decoded combinationally from `state`. `pcen` additionally depends on `zero`, and `alucontrol` on `funct`.

## Timing
- Reset (`reset` = 0): state is forced to FETCH immediately, asynchronously. While reset is held, every strobe output, `illegal_op` and `alucontrol` are forced to 0. `state` reads the FETCH encoding (0).
- First fetch: the first rising edge after `reset` goes high performs the fetch (irwrite, pcen).
- Cycle counts, FETCH through the final state inclusive:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - Illegal opcode: 2
- `op` and `funct` must be stable from the DECODE cycle until the instruction completes. The instruction register is written only in FETCH, which guarantees this.
- `zero` is sampled combinationally in BEQEX only.
- If reset is asserted mid-instruction, the instruction is abandoned. No further regwrite or memwrite occurs, even when reset arrives during a MEMWR or *WB cycle before the edge.

## Test plan
- lw (op 100011):
  - `state` sequence is FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - MEMRD has iord=1.
  - MEMWB has regwrite=1, memtoreg=1, regdst=0.
  - memwrite stays 0 throughout.
- sw (op 101011): 4 cycles. memwrite=1 only in the MEMWR cycle. regwrite never asserts.
- R-type (op 000000) with funct 100000 and then 101010:
  - alucontrol is 010, then 111, in RTYPEEX.
  - RTYPEWB has regwrite=1, regdst=1.
  - funct 111111 gives 010.
- beq:
  - zero=1 in BEQEX gives pcen=1, pcsrc=01.
  - zero=0 gives pcen=0.
  - Both cases return to FETCH after 3 cycles.
- j and illegal opcode:
  - j (000010) gives JEX with pcsrc=10, pcen=1.
  - op 111111 pulses illegal_op for exactly one cycle in DECODE, then FETCH.
- Reset:
  - Drop `reset` to 0 mid-MEMRD of an lw. `state` goes to 0 without waiting for a clock edge, and all strobes read 0.
  - After release, the next instruction starts a normal FETCH, DECODE sequence.
